// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared opcodes, state encoding and word width for the fetch stage
package pc_fetch_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// rtl/pc_fetch_unit_next_pc_calc.sv - combinational next-pc selection for seq, beq/bne and j
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = OP_HALT
) (
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instruction,
  input  logic              alu_zero,
  output logic [WORD_W-1:0] next_pc,
  output logic              is_halt
);

  logic [5:0]        op;
  logic [15:0]       imm;
  logic [WORD_W-1:0] seq_pc;
  logic [WORD_W-1:0] branch_pc;
  logic [WORD_W-1:0] jump_pc;

  assign op        = instruction[31:26];
  assign imm       = instruction[15:0];
  assign seq_pc    = pc + 32'd4;
  // Signed word offset relative to the following instruction.
  assign branch_pc = seq_pc + {{14{imm[15]}}, imm, 2'b00};
  assign jump_pc   = {seq_pc[31:28], instruction[25:0], 2'b00};
  assign is_halt   = (op == HALT_OPCODE);

  always_comb begin
    next_pc = seq_pc;
    case (op)
      OP_BEQ:  next_pc = alu_zero ? branch_pc : seq_pc;
      OP_BNE:  next_pc = alu_zero ? seq_pc : branch_pc;
      OP_J:    next_pc = jump_pc;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register, fetch FSM, halt/fault detection and retire counter
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 64,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(IMEM_WORDS * 4);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] next_pc;
  logic              is_halt;
  logic              retire;
  logic              out_of_range;

  next_pc_calc #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_next_pc_calc (
    .pc         (pc),
    .instruction(instruction),
    .alu_zero   (alu_zero),
    .next_pc    (next_pc),
    .is_halt    (is_halt)
  );

  assign pc_plus4     = pc + 32'd4;
  assign retire       = (state == S_RUN) && !stall;
  assign out_of_range = !is_halt && (next_pc >= PC_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   if (retire && (is_halt || out_of_range)) state_next = S_HALT;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_BOOT;
    endcase
  end

  always_comb begin
    pc_valid = 1'b0;
    halted   = 1'b0;
    case (state)
      S_RUN:   pc_valid = 1'b1;
      S_HALT:  halted   = 1'b1;
      default: ;
    endcase
  end

  // The halting instruction still counts as retired; only normal retires move pc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      retired_count <= '0;
      fault         <= 1'b0;
    end else if (retire) begin
      retired_count <= retired_count + 32'd1;
      if (!is_halt && !out_of_range) begin
        pc <= next_pc;
      end
      if (out_of_range) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] instruction;
  logic        alu_zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  int errors;
  int checks;

  localparam logic [31:0] I_ADD  = 32'h0000_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .instruction  (instruction),
    .alu_zero     (alu_zero),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .fault        (fault),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_halted, input logic e_fault, input logic [31:0] e_cnt);
    check({tag, "_pc"}, pc, e_pc);
    check({tag, "_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, e_halted});
    check({tag, "_fault"}, {31'd0, fault}, {31'd0, e_fault});
    check({tag, "_count"}, retired_count, e_cnt);
  endtask

  task automatic step(input logic [31:0] instr, input logic az);
    instruction = instr;
    alu_zero    = az;
    tick();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    instruction = I_ADD;
    alu_zero    = 1'b0;

    tick();
    tick();
    check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

    rst_n = 1'b1;
    tick();
    check_state("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("pc_plus4_0", pc_plus4, 32'h4);
    step(I_ADD, 1'b0);
    check_state("seq1", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    step(I_ADD, 1'b0);
    check_state("seq2", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(I_ADD, 1'b0);
      check_state("stall", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
    end
    stall = 1'b0;
    step(I_ADD, 1'b0);
    check_state("unstall", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);
    step(I_ADD, 1'b0);
    check("seq_0x10", pc, 32'h10);

    step(32'h1000_0003, 1'b1);
    check_state("beq_taken", 32'h20, 1'b1, 1'b0, 1'b0, 32'd5);
    step(32'h0800_0004, 1'b0);
    check("j_back1", pc, 32'h10);
    step(32'h1000_0003, 1'b0);
    check("beq_not_taken", pc, 32'h14);
    step(32'h0800_0004, 1'b0);
    step(32'h1400_0003, 1'b0);
    check("bne_taken", pc, 32'h20);
    step(32'h0800_0004, 1'b0);
    step(32'h1400_0003, 1'b1);
    check_state("bne_not_taken", 32'h14, 1'b1, 1'b0, 1'b0, 32'd11);
    step(32'h0800_0004, 1'b0);

    step(32'h1000_FFFF, 1'b1);
    check_state("self_loop1", 32'h10, 1'b1, 1'b0, 1'b0, 32'd13);
    step(32'h1000_FFFF, 1'b1);
    check_state("self_loop2", 32'h10, 1'b1, 1'b0, 1'b0, 32'd14);

    step(32'h0800_0005, 1'b0);
    check("jump_0x14", pc, 32'h14);
    step(32'h0800_0004, 1'b0);
    step(32'h0800_0002, 1'b0);
    check_state("jump_0x08", 32'h8, 1'b1, 1'b0, 1'b0, 32'd17);
    step(I_ADD, 1'b0);
    check("seq_0xC", pc, 32'hC);

    step(I_HALT, 1'b0);
    check_state("halt", 32'hC, 1'b0, 1'b1, 1'b0, 32'd19);
    stall = 1'b1;
    step(I_ADD, 1'b0);
    stall = 1'b0;
    step(I_ADD, 1'b0);
    step(32'h0800_0001, 1'b1);
    check_state("halt_frozen", 32'hC, 1'b0, 1'b1, 1'b0, 32'd19);

    rst_n = 1'b0;
    step(I_ADD, 1'b0);
    check_state("reset_in_halt", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step(I_ADD, 1'b0);
    check("boot_to_run", {31'd0, pc_valid}, 32'd1);

    step(32'h0800_003F, 1'b0);
    check_state("jump_0xFC", 32'hFC, 1'b1, 1'b0, 1'b0, 32'd1);
    check("pc_plus4_FC", pc_plus4, 32'h100);
    step(I_ADD, 1'b0);
    check_state("fault", 32'hFC, 1'b0, 1'b1, 1'b1, 32'd2);
    step(I_ADD, 1'b0);
    check_state("fault_frozen", 32'hFC, 1'b0, 1'b1, 1'b1, 32'd2);

    rst_n = 1'b0;
    step(I_ADD, 1'b0);
    check_state("reset_after_fault", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step(I_ADD, 1'b0);
    step(I_ADD, 1'b0);
    check_state("run_again", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    stall = 1'b1;
    step(I_ADD, 1'b0);
    rst_n = 1'b0;
    step(I_ADD, 1'b0);
    check_state("reset_in_stall", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    step(I_ADD, 1'b0);
    step(I_ADD, 1'b0);
    check_state("stall_after_boot", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
